// File: rtl/track_follow_ctrl.sv
// track_follow_ctrl
// Line-following motor controller. Debounces the 3-bit line-sensor code, runs a
// follow/search/stop state machine on the debounced code and drives two H-bridge
// channels as a registered PWM level plus a 2-bit direction per side.
// Duty and direction reach the pins only at a PWM period boundary, so a channel
// never sees a truncated or stretched pulse. The one exception is shutdown:
// going to IDLE or STOP turns both motors off at once.
module track_follow_ctrl #(
    parameter int PWM_BITS       = 10,
    parameter int DEBOUNCE       = 4,
    parameter int LOST_TIMEOUT   = 50000,
    parameter int SEARCH_TIMEOUT = 2000000,
    parameter int SPEED_FAST     = 900,
    parameter int SPEED_SLOW     = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] detect_road,
    output logic       left_pwm,
    output logic       right_pwm,
    output logic [1:0] left_dir,
    output logic [1:0] right_dir,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_STRAIGHT = 3'd1,
        ST_LEFT     = 3'd2,
        ST_RIGHT    = 3'd3,
        ST_SEARCH   = 3'd4,
        ST_STOP     = 3'd5
    } state_t;

    localparam int DB_W     = $clog2(DEBOUNCE + 1);
    localparam int LOST_W   = $clog2(LOST_TIMEOUT + 1);
    localparam int SEARCH_W = $clog2(SEARCH_TIMEOUT + 1);

    localparam logic [DB_W-1:0]     DB_FULL    = DB_W'(DEBOUNCE);
    localparam logic [DB_W-1:0]     DB_ONE     = DB_W'(1);
    localparam logic [LOST_W-1:0]   LOST_LAST  = LOST_W'(LOST_TIMEOUT - 1);
    localparam logic [SEARCH_W-1:0] SRCH_LAST  = SEARCH_W'(SEARCH_TIMEOUT - 1);
    localparam logic [PWM_BITS-1:0] DUTY_FAST  = PWM_BITS'(SPEED_FAST);
    localparam logic [PWM_BITS-1:0] DUTY_SLOW  = PWM_BITS'(SPEED_SLOW);
    localparam logic [PWM_BITS-1:0] DUTY_ZERO  = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0] PWM_MAX    = {PWM_BITS{1'b1}};

    localparam logic [1:0] DIR_OFF = 2'b00;
    localparam logic [1:0] DIR_REV = 2'b01;
    localparam logic [1:0] DIR_FWD = 2'b10;

    localparam logic SIDE_LEFT  = 1'b0;
    localparam logic SIDE_RIGHT = 1'b1;

    // Reject duty values the counter can never exceed and a zero-length debounce.
    if ((SPEED_FAST >= (1 << PWM_BITS)) || (SPEED_SLOW >= (1 << PWM_BITS)) ||
        (SPEED_FAST < 0) || (SPEED_SLOW < 0) || (DEBOUNCE < 1) ||
        (LOST_TIMEOUT < 1) || (SEARCH_TIMEOUT < 1)) begin : g_param_check
        $error("track_follow_ctrl: illegal parameter combination");
    end

    // Debounce and tracking state
    logic [2:0]          cand_r;
    logic [DB_W-1:0]     db_cnt_r;
    logic [DB_W-1:0]     db_cnt_s;
    logic [2:0]          stable_r;
    logic                last_side_r;

    // FSM state and timers
    state_t              state_r;
    state_t              state_s;
    logic [LOST_W-1:0]   lost_cnt_r;
    logic [LOST_W-1:0]   lost_cnt_s;
    logic [SEARCH_W-1:0] search_cnt_r;
    logic [SEARCH_W-1:0] search_cnt_s;

    // Commanded motor settings (follow the FSM every cycle)
    logic [PWM_BITS-1:0] cmd_duty_l_r, cmd_duty_r_r;
    logic [PWM_BITS-1:0] cmd_duty_l_s, cmd_duty_r_s;
    logic [1:0]          cmd_dir_l_r, cmd_dir_r_r;
    logic [1:0]          cmd_dir_l_s, cmd_dir_r_s;

    // Output stage (updated at period boundaries)
    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic [PWM_BITS-1:0] duty_l_r, duty_r_r;
    logic [1:0]          dir_l_r, dir_r_r;
    logic                pwm_l_r, pwm_r_r;
    logic                force_off_s;

    // Next run length of the current candidate code; saturates once accepted.
    always_comb begin
        db_cnt_s = db_cnt_r;
        if (detect_road == cand_r) begin
            if (db_cnt_r == DB_FULL) begin
                db_cnt_s = db_cnt_r;
            end else begin
                db_cnt_s = db_cnt_r + DB_ONE;
            end
        end else begin
            db_cnt_s = DB_ONE;
        end
    end

    // Candidate tracking and promotion of a run of DEBOUNCE identical codes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cand_r   <= 3'b010;
            db_cnt_r <= {DB_W{1'b0}};
            stable_r <= 3'b010;
        end else begin
            cand_r   <= detect_road;
            db_cnt_r <= db_cnt_s;
            if (db_cnt_s == DB_FULL) begin
                stable_r <= detect_road;
            end else begin
                stable_r <= stable_r;
            end
        end
    end

    // Remember which side the line was last seen on, for the search pivot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_side_r <= SIDE_LEFT;
        end else begin
            case (stable_r)
                3'b100, 3'b110: last_side_r <= SIDE_LEFT;
                3'b001, 3'b011: last_side_r <= SIDE_RIGHT;
                default:        last_side_r <= last_side_r;
            endcase
        end
    end

    // Next-state and timer logic; enable low overrides everything.
    always_comb begin
        state_s      = state_r;
        lost_cnt_s   = {LOST_W{1'b0}};
        search_cnt_s = {SEARCH_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_s = ST_STRAIGHT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_STRAIGHT, ST_LEFT, ST_RIGHT: begin
                case (stable_r)
                    3'b010, 3'b101: state_s = ST_STRAIGHT;
                    3'b100, 3'b110: state_s = ST_LEFT;
                    3'b001, 3'b011: state_s = ST_RIGHT;
                    3'b111:         state_s = ST_STOP;
                    3'b000: begin
                        if (lost_cnt_r == LOST_LAST) begin
                            state_s = ST_SEARCH;
                        end else begin
                            state_s = state_r;
                        end
                    end
                    default:        state_s = state_r;
                endcase
            end
            ST_SEARCH: begin
                // A valid code always beats the timeout.
                case (stable_r)
                    3'b010, 3'b101: state_s = ST_STRAIGHT;
                    3'b100, 3'b110: state_s = ST_LEFT;
                    3'b001, 3'b011: state_s = ST_RIGHT;
                    3'b111:         state_s = ST_STOP;
                    default: begin
                        if (search_cnt_r == SRCH_LAST) begin
                            state_s = ST_STOP;
                        end else begin
                            state_s = ST_SEARCH;
                        end
                    end
                endcase
            end
            ST_STOP: state_s = ST_STOP;
            default: state_s = ST_IDLE;
        endcase

        if (!enable) begin
            state_s = ST_IDLE;
        end else begin
            state_s = state_s;
        end

        // Timers run only while staying put; any entry starts them from zero.
        if ((state_s == state_r) && (stable_r == 3'b000) &&
            ((state_r == ST_STRAIGHT) || (state_r == ST_LEFT) || (state_r == ST_RIGHT))) begin
            lost_cnt_s = lost_cnt_r + LOST_W'(1);
        end else begin
            lost_cnt_s = {LOST_W{1'b0}};
        end

        if ((state_s == ST_SEARCH) && (state_r == ST_SEARCH)) begin
            search_cnt_s = search_cnt_r + SEARCH_W'(1);
        end else begin
            search_cnt_s = {SEARCH_W{1'b0}};
        end
    end

    // State register and timers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            lost_cnt_r   <= {LOST_W{1'b0}};
            search_cnt_r <= {SEARCH_W{1'b0}};
        end else begin
            state_r      <= state_s;
            lost_cnt_r   <= lost_cnt_s;
            search_cnt_r <= search_cnt_s;
        end
    end

    // Motor command for the state being entered; a lost line keeps the last command.
    always_comb begin
        cmd_duty_l_s = cmd_duty_l_r;
        cmd_duty_r_s = cmd_duty_r_r;
        cmd_dir_l_s  = cmd_dir_l_r;
        cmd_dir_r_s  = cmd_dir_r_r;
        case (state_s)
            ST_STRAIGHT: begin
                cmd_duty_l_s = DUTY_FAST; cmd_dir_l_s = DIR_FWD;
                cmd_duty_r_s = DUTY_FAST; cmd_dir_r_s = DIR_FWD;
            end
            ST_LEFT: begin
                case (stable_r)
                    3'b110: begin
                        cmd_duty_l_s = DUTY_SLOW; cmd_dir_l_s = DIR_FWD;
                        cmd_duty_r_s = DUTY_FAST; cmd_dir_r_s = DIR_FWD;
                    end
                    3'b100: begin
                        cmd_duty_l_s = DUTY_SLOW; cmd_dir_l_s = DIR_REV;
                        cmd_duty_r_s = DUTY_FAST; cmd_dir_r_s = DIR_FWD;
                    end
                    default: begin
                        cmd_duty_l_s = cmd_duty_l_r; cmd_dir_l_s = cmd_dir_l_r;
                        cmd_duty_r_s = cmd_duty_r_r; cmd_dir_r_s = cmd_dir_r_r;
                    end
                endcase
            end
            ST_RIGHT: begin
                case (stable_r)
                    3'b011: begin
                        cmd_duty_l_s = DUTY_FAST; cmd_dir_l_s = DIR_FWD;
                        cmd_duty_r_s = DUTY_SLOW; cmd_dir_r_s = DIR_FWD;
                    end
                    3'b001: begin
                        cmd_duty_l_s = DUTY_FAST; cmd_dir_l_s = DIR_FWD;
                        cmd_duty_r_s = DUTY_SLOW; cmd_dir_r_s = DIR_REV;
                    end
                    default: begin
                        cmd_duty_l_s = cmd_duty_l_r; cmd_dir_l_s = cmd_dir_l_r;
                        cmd_duty_r_s = cmd_duty_r_r; cmd_dir_r_s = cmd_dir_r_r;
                    end
                endcase
            end
            ST_SEARCH: begin
                if (last_side_r == SIDE_LEFT) begin
                    cmd_duty_l_s = DUTY_SLOW; cmd_dir_l_s = DIR_REV;
                    cmd_duty_r_s = DUTY_SLOW; cmd_dir_r_s = DIR_FWD;
                end else begin
                    cmd_duty_l_s = DUTY_SLOW; cmd_dir_l_s = DIR_FWD;
                    cmd_duty_r_s = DUTY_SLOW; cmd_dir_r_s = DIR_REV;
                end
            end
            default: begin
                cmd_duty_l_s = DUTY_ZERO; cmd_dir_l_s = DIR_OFF;
                cmd_duty_r_s = DUTY_ZERO; cmd_dir_r_s = DIR_OFF;
            end
        endcase
    end

    // Command registers, aligned with the state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cmd_duty_l_r <= DUTY_ZERO;
            cmd_duty_r_r <= DUTY_ZERO;
            cmd_dir_l_r  <= DIR_OFF;
            cmd_dir_r_r  <= DIR_OFF;
        end else begin
            cmd_duty_l_r <= cmd_duty_l_s;
            cmd_duty_r_r <= cmd_duty_r_s;
            cmd_dir_l_r  <= cmd_dir_l_s;
            cmd_dir_r_r  <= cmd_dir_r_s;
        end
    end

    assign force_off_s = (state_s == ST_IDLE) || (state_s == ST_STOP);

    // PWM counter, period-boundary latching of duty/dir, and registered pwm levels.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pwm_cnt_r <= DUTY_ZERO;
            duty_l_r  <= DUTY_ZERO;
            duty_r_r  <= DUTY_ZERO;
            dir_l_r   <= DIR_OFF;
            dir_r_r   <= DIR_OFF;
            pwm_l_r   <= 1'b0;
            pwm_r_r   <= 1'b0;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
            if (force_off_s) begin
                duty_l_r <= DUTY_ZERO;
                duty_r_r <= DUTY_ZERO;
                dir_l_r  <= DIR_OFF;
                dir_r_r  <= DIR_OFF;
                pwm_l_r  <= 1'b0;
                pwm_r_r  <= 1'b0;
            end else begin
                if (pwm_cnt_r == PWM_MAX) begin
                    duty_l_r <= cmd_duty_l_r;
                    duty_r_r <= cmd_duty_r_r;
                    dir_l_r  <= cmd_dir_l_r;
                    dir_r_r  <= cmd_dir_r_r;
                end else begin
                    duty_l_r <= duty_l_r;
                    duty_r_r <= duty_r_r;
                    dir_l_r  <= dir_l_r;
                    dir_r_r  <= dir_r_r;
                end
                pwm_l_r <= (pwm_cnt_r < duty_l_r);
                pwm_r_r <= (pwm_cnt_r < duty_r_r);
            end
        end
    end

    assign left_pwm  = pwm_l_r;
    assign right_pwm = pwm_r_r;
    assign left_dir  = dir_l_r;
    assign right_dir = dir_r_r;
    assign state     = state_r;

endmodule

// File: tb/tb_track_follow_ctrl.sv
// Directed bench for track_follow_ctrl with short timers and a 16-cycle PWM period.
module tb_track_follow_ctrl;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [2:0] detect_road;
    logic       left_pwm;
    logic       right_pwm;
    logic [1:0] left_dir;
    logic [1:0] right_dir;
    logic [2:0] state;

    int total;
    int bad;
    int cyc;
    int latch_cyc;
    int nl;
    int nr;

    track_follow_ctrl #(
        .PWM_BITS      (4),
        .DEBOUNCE      (2),
        .LOST_TIMEOUT  (8),
        .SEARCH_TIMEOUT(16),
        .SPEED_FAST    (12),
        .SPEED_SLOW    (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .detect_road(detect_road),
        .left_pwm   (left_pwm),
        .right_pwm  (right_pwm),
        .left_dir   (left_dir),
        .right_dir  (right_dir),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Count pwm high samples over n cycles.
    task automatic count_pwm(input int n, output int cl, output int cr);
        cl = 0;
        cr = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (left_pwm === 1'b1) cl++;
            if (right_pwm === 1'b1) cr++;
        end
    endtask

    // Advance to the sample right after a period boundary.
    task automatic align();
        while (((cyc - latch_cyc) % 16) != 0) step(1);
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; latch_cyc = 0;
        reset = 1'b0; enable = 1'b0; detect_road = 3'b010;

        // 1: reset, start, straight drive at 12/16
        step(3);
        check("rst_state", state, 3'd0);
        check("rst_lpwm", left_pwm, 1'b0);
        check("rst_rpwm", right_pwm, 1'b0);
        check("rst_ldir", left_dir, 2'b00);
        check("rst_rdir", right_dir, 2'b00);
        reset = 1'b1; enable = 1'b1;
        step(1);
        check("start_state", state, 3'd1);
        for (int i = 0; i < 40 && left_dir !== 2'b10; i++) step(1);
        latch_cyc = cyc;
        check("straight_ldir", left_dir, 2'b10);
        check("straight_rdir", right_dir, 2'b10);
        count_pwm(16, nl, nr);
        check("straight_lhigh", nl, 12);
        check("straight_rhigh", nr, 12);

        // 2: glitch rejection, then sharp left
        detect_road = 3'b110;
        step(1);
        detect_road = 3'b010;
        step(4);
        check("glitch_state", state, 3'd1);
        detect_road = 3'b100;
        step(2);
        check("left_debounce_state", state, 3'd1);
        step(1);
        check("left_state", state, 3'd2);
        for (int i = 0; i < 40 && left_dir !== 2'b01; i++) step(1);
        check("left_ldir", left_dir, 2'b01);
        check("left_rdir", right_dir, 2'b10);
        align();
        count_pwm(16, nl, nr);
        check("left_lhigh", nl, 4);
        check("left_rhigh", nr, 12);

        // 3: lost line from LEFT, search pivots left, 011 recovers to RIGHT
        align();
        detect_road = 3'b000;
        step(9);
        check("lost_hold_state", state, 3'd2);
        check("lost_hold_ldir", left_dir, 2'b01);
        step(1);
        check("search_state", state, 3'd4);
        step(6);
        check("search_ldir", left_dir, 2'b01);
        check("search_rdir", right_dir, 2'b10);
        count_pwm(5, nl, nr);
        check("search_lhigh", nl, 4);
        check("search_rhigh", nr, 4);
        detect_road = 3'b011;
        step(2);
        check("search_debounce_state", state, 3'd4);
        step(1);
        check("recover_right_state", state, 3'd3);

        // 4: gentle right, search toward right, timeout to STOP, enable drop
        align();
        check("gentle_right_ldir", left_dir, 2'b10);
        check("gentle_right_rdir", right_dir, 2'b10);
        detect_road = 3'b000;
        step(10);
        check("search2_state", state, 3'd4);
        step(15);
        check("search2_hold_state", state, 3'd4);
        check("search2_ldir", left_dir, 2'b10);
        check("search2_rdir", right_dir, 2'b01);
        step(1);
        check("timeout_stop_state", state, 3'd5);
        check("stop_ldir", left_dir, 2'b00);
        check("stop_rdir", right_dir, 2'b00);
        count_pwm(16, nl, nr);
        check("stop_lhigh", nl, 0);
        check("stop_rhigh", nr, 0);
        enable = 1'b0;
        step(1);
        check("disable_idle_state", state, 3'd0);

        // 5: stop marker, STOP held until enable toggles
        enable = 1'b1; detect_road = 3'b010;
        step(4);
        check("restart_state", state, 3'd1);
        detect_road = 3'b111;
        step(2);
        check("marker_debounce_state", state, 3'd1);
        step(1);
        check("marker_stop_state", state, 3'd5);
        check("marker_lpwm", left_pwm, 1'b0);
        check("marker_ldir", left_dir, 2'b00);
        detect_road = 3'b010;
        step(6);
        check("stop_held_state", state, 3'd5);
        enable = 1'b0;
        step(1);
        check("toggle_idle_state", state, 3'd0);
        enable = 1'b1;
        step(1);
        check("toggle_run_state", state, 3'd1);

        // 6: reset mid-search; last_side returns to LEFT
        detect_road = 3'b001;
        step(3);
        check("sharp_right_state", state, 3'd3);
        detect_road = 3'b000;
        step(10);
        check("search3_state", state, 3'd4);
        reset = 1'b0;
        step(1);
        check("midrst_state", state, 3'd0);
        check("midrst_lpwm", left_pwm, 1'b0);
        check("midrst_rpwm", right_pwm, 1'b0);
        check("midrst_ldir", left_dir, 2'b00);
        check("midrst_rdir", right_dir, 2'b00);
        reset = 1'b1;
        step(16);
        check("postrst_search_state", state, 3'd4);
        check("postrst_ldir", left_dir, 2'b01);
        check("postrst_rdir", right_dir, 2'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
